// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the mul/div sequencer state encoding and the operand forwarding select codes.
// Imported by hazard_md_fsm and hazard_ctrl.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from Writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from Memory-stage result

endpackage

// File: rtl/hazard_md_fsm.sv
// Multi-cycle mul/div sequencer: asserts md_busy for MD_CYCLES cycles starting in the
// cycle md_start_e is seen in IDLE, then pulses md_done for one cycle.
// Ports: clk, rst (sync active-low), md_start_e, branch_taken_e in; md_busy, md_done out.
module hazard_md_fsm
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_e,
  input  logic branch_taken_e,
  output logic md_busy,
  output logic md_done
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_busy = 1'b0;
    md_done = 1'b0;
    case (state_q)
      IDLE: begin
        // A start in the shadow of a taken branch is being squashed, so ignore it.
        if (md_start_e && !branch_taken_e) begin
          md_busy = 1'b1;
          cnt_d   = CW'(MD_CYCLES - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // md_start_e may still be high here (same instruction leaving E); not a new op.
        md_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      md_busy = 1'b0;
      md_done = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stage enables/flushes, E-stage
// forwarding selects, mul/div front-end freeze, saturating count of D-stall cycles.
// Ports: clk, rst (sync active-low), register indices/controls per stage in;
// en_*/flush_*/bubble_m, fwd_a_e/fwd_b_e, md_busy/md_done, stall_cnt out.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RW        = 5,
  parameter int MD_CYCLES = 4,
  parameter int SCW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RW-1:0]  rs_d,
  input  logic [RW-1:0]  rt_d,
  input  logic [RW-1:0]  rs_e,
  input  logic [RW-1:0]  rt_e,
  input  logic [RW-1:0]  rd_e,
  input  logic [RW-1:0]  rd_m,
  input  logic [RW-1:0]  rd_w,
  input  logic           regwrite_e,
  input  logic           regwrite_m,
  input  logic           regwrite_w,
  input  logic           memtoreg_e,
  input  logic           branch_taken_e,
  input  logic           md_start_e,
  output logic           en_f,
  output logic           en_d,
  output logic           en_e,
  output logic           en_m,
  output logic           flush_d,
  output logic           flush_e,
  output logic           bubble_m,
  output logic [1:0]     fwd_a_e,
  output logic [1:0]     fwd_b_e,
  output logic           md_busy,
  output logic           md_done,
  output logic [SCW-1:0] stall_cnt
);

  logic           lu;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

  hazard_md_fsm #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md_fsm (
    .clk            (clk),
    .rst            (rst),
    .md_start_e     (md_start_e),
    .branch_taken_e (branch_taken_e),
    .md_busy        (md_busy),
    .md_done        (md_done)
  );

  // M-stage result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src, input logic wm,
                                         input logic [RW-1:0] dm, input logic ww,
                                         input logic [RW-1:0] dw);
    if (wm && dm != '0 && dm == src)      return FWD_M;
    else if (ww && dw != '0 && dw == src) return FWD_W;
    else                                  return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (rst) begin
      fwd_a_e = fwd_sel(rs_e, regwrite_m, rd_m, regwrite_w, rd_w);
      fwd_b_e = fwd_sel(rt_e, regwrite_m, rd_m, regwrite_w, rd_w);
    end
  end

  assign lu = memtoreg_e && regwrite_e && (rd_e != '0) && (rd_e == rs_d || rd_e == rt_d);

  // Priority: mul/div freeze > taken branch > load-use. md_busy is already 0 in reset.
  always_comb begin
    en_f     = 1'b1;
    en_d     = 1'b1;
    en_e     = 1'b1;
    en_m     = 1'b1;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_m = 1'b0;
    if (rst) begin
      if (md_busy) begin
        en_f     = 1'b0;
        en_d     = 1'b0;
        en_e     = 1'b0;
        bubble_m = 1'b1;
      end else if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        en_f    = 1'b0;
        en_d    = 1'b0;
        flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!en_d && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + SCW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int RW  = 5;
  localparam int MDC = 4;
  localparam int SCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, rd_e, rd_m, rd_w;
  logic          regwrite_e, regwrite_m, regwrite_w, memtoreg_e, branch_taken_e, md_start_e;
  logic          en_f, en_d, en_e, en_m, flush_d, flush_e, bubble_m, md_busy, md_done;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic [SCW-1:0] stall_cnt;

  hazard_ctrl #(.RW(RW), .MD_CYCLES(MDC), .SCW(SCW)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .branch_taken_e(branch_taken_e), .md_start_e(md_start_e),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
    .flush_d(flush_d), .flush_e(flush_e), .bubble_m(bubble_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: stall cycles still owed by an accepted mul/div, whether the
  // result-valid cycle is due now, and the stall count as a plain integer.
  int md_left  = 0;
  bit md_due   = 1'b0;
  int sc_model = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] src);
    if (regwrite_m && rd_m != 0 && rd_m == src) return 2'b10;
    if (regwrite_w && rd_w != 0 && rd_w == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0;
    branch_taken_e = 0; md_start_e = 0;
  endtask

  // Inputs are already applied (at edge+1); check at edge+2, then advance one clock.
  task automatic cycle();
    bit busy, done, lu, ef, ed, ee, fd, fe, bm;
    logic [1:0] fa, fb;
    #1;
    lu   = memtoreg_e && regwrite_e && rd_e != 0 && (rd_e == rs_d || rd_e == rt_d);
    busy = rst && (md_left > 0 || (!md_due && md_start_e && !branch_taken_e));
    done = rst && md_due;
    ef = 1; ed = 1; ee = 1; fd = 0; fe = 0; bm = 0;
    fa = rst ? ref_fwd(rs_e) : 2'b00;
    fb = rst ? ref_fwd(rt_e) : 2'b00;
    if (rst) begin
      if (busy) begin ef = 0; ed = 0; ee = 0; bm = 1; end
      else if (branch_taken_e) begin fd = 1; fe = 1; end
      else if (lu) begin ef = 0; ed = 0; fe = 1; end
    end
    chk("en_f", 16'(en_f), 16'(ef));
    chk("en_d", 16'(en_d), 16'(ed));
    chk("en_e", 16'(en_e), 16'(ee));
    chk("en_m", 16'(en_m), 16'(1));
    chk("flush_d", 16'(flush_d), 16'(fd));
    chk("flush_e", 16'(flush_e), 16'(fe));
    chk("bubble_m", 16'(bubble_m), 16'(bm));
    chk("fwd_a_e", 16'(fwd_a_e), 16'(fa));
    chk("fwd_b_e", 16'(fwd_b_e), 16'(fb));
    chk("md_busy", 16'(md_busy), 16'(busy));
    chk("md_done", 16'(md_done), 16'(done));
    chk("stall_cnt", 16'(stall_cnt), 16'(sc_model));
    @(posedge clk);
    if (!rst) begin
      md_left = 0; md_due = 0; sc_model = 0;
    end else begin
      if (!ed && sc_model < (1 << SCW) - 1) sc_model++;
      if (md_left > 0) begin
        md_left--;
        md_due = (md_left == 0);
      end else if (busy) begin
        md_left = MDC - 1;
        md_due  = 0;
      end else begin
        md_due = 0;
      end
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    @(posedge clk); #1;

    // Reset state
    cycle();
    rst = 1;
    cycle();

    // Forwarding priority and zero-register exclusion
    rs_e = 3; rd_m = 3; regwrite_m = 1; rd_w = 3; regwrite_w = 1;
    cycle(); chk("fwd_m_prio", 16'(fwd_a_e), 16'(2'b10));
    regwrite_m = 0;
    cycle(); chk("fwd_w", 16'(fwd_a_e), 16'(2'b01));
    regwrite_m = 1; rd_m = 0; rd_w = 0;
    cycle(); chk("fwd_r0", 16'(fwd_a_e), 16'(2'b00));
    clear_inputs();

    // Load-use: one stall cycle
    memtoreg_e = 1; regwrite_e = 1; rd_e = 7; rs_d = 7;
    cycle(); chk("lu_cnt", 16'(stall_cnt), 16'(1));
    // Branch overrides load-use
    branch_taken_e = 1;
    cycle(); chk("br_lu_cnt", 16'(stall_cnt), 16'(1));
    clear_inputs();
    cycle();

    // Mul/div with start held through DONE, branch in cycle 2 ignored
    md_start_e = 1;
    for (int c = 0; c < 5; c++) begin
      branch_taken_e = (c == 2);
      cycle();
    end
    chk("md_cnt", 16'(stall_cnt), 16'(5));
    clear_inputs();
    cycle();

    // Reset in the middle of a mul/div
    md_start_e = 1;
    cycle(); cycle();
    rst = 0;
    cycle();
    rst = 1; md_start_e = 0;
    chk("rst_mid_cnt", 16'(stall_cnt), 16'(0));
    cycle(); cycle(); cycle(); cycle();

    // Saturation of the stall counter
    memtoreg_e = 1; regwrite_e = 1; rd_e = 5; rt_d = 5;
    for (int c = 0; c < 20; c++) cycle();
    chk("sat_cnt", 16'(stall_cnt), 16'(15));
    clear_inputs();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst            = ($urandom_range(0, 24) != 0);
      rs_d           = RW'($urandom_range(0, 3));
      rt_d           = RW'($urandom_range(0, 3));
      rs_e           = RW'($urandom_range(0, 3));
      rt_e           = RW'($urandom_range(0, 3));
      rd_e           = RW'($urandom_range(0, 3));
      rd_m           = RW'($urandom_range(0, 3));
      rd_w           = RW'($urandom_range(0, 3));
      regwrite_e     = ($urandom_range(0, 1) != 0);
      regwrite_m     = ($urandom_range(0, 1) != 0);
      regwrite_w     = ($urandom_range(0, 1) != 0);
      memtoreg_e     = ($urandom_range(0, 2) == 0);
      branch_taken_e = ($urandom_range(0, 4) == 0);
      md_start_e     = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
